// File: rtl/fir_package.sv
// Shared TCDM constants and request record for the FIR accelerator and its
// behavioural memory responder.
package fir_package;
  localparam int TCDM_DW = 32;
  localparam int TCDM_BW = 4;

  typedef struct packed {
    logic [31:0]        add;
    logic               wen;
    logic [TCDM_BW-1:0] be;
    logic [TCDM_DW-1:0] data;
  } tcdm_req_t;
endpackage

// File: rtl/fir_tcdm_bank.sv
// One word-wide TCDM bank: byte-enabled write, registered read data and a
// registered valid/owner tag so the top can route the response to its port.
module fir_tcdm_bank import fir_package::*; #(
  parameter int BANK_WORDS = 256,
  parameter int OW         = 2,
  parameter int RW         = $clog2(BANK_WORDS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               gnt_i,
  input  logic [OW-1:0]      owner_i,
  input  logic [RW-1:0]      row_i,
  input  logic               wen_i,
  input  logic [TCDM_BW-1:0] be_i,
  input  logic [TCDM_DW-1:0] wdata_i,
  output logic               rvalid_o,
  output logic [OW-1:0]      owner_o,
  output logic [TCDM_DW-1:0] rdata_o
);
  logic [TCDM_DW-1:0] mem_q [BANK_WORDS];
  logic               rvalid_q;
  logic [OW-1:0]      owner_q;
  logic [TCDM_DW-1:0] rdata_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BANK_WORDS; i++) mem_q[i] <= '0;
    end else if (gnt_i && !wen_i) begin
      for (int j = 0; j < TCDM_BW; j++)
        if (be_i[j]) mem_q[row_i][8*j +: 8] <= wdata_i[8*j +: 8];
    end
  end

  // Read sees the array before this edge's write; a write in the previous
  // cycle has already landed, giving read-after-write on the next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      owner_q  <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt_i;
      owner_q  <= owner_i;
      rdata_q  <= (gnt_i && wen_i) ? mem_q[row_i] : '0;
    end
  end

  assign rvalid_o = rvalid_q;
  assign owner_o  = owner_q;
  assign rdata_o  = rdata_q;
endmodule

// File: rtl/fir_tcdm_responder.sv
// Multi-port TCDM memory model: word-interleaved banks, per-bank round-robin
// arbitration with forced stalls, and a one-cycle response pipeline.
module fir_tcdm_responder import fir_package::*; #(
  parameter int MP         = 4,
  parameter int N_BANKS    = 8,
  parameter int BANK_WORDS = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [MP-1:0]                 tcdm_req,
  output logic [MP-1:0]                 tcdm_gnt,
  input  logic [MP-1:0][31:0]           tcdm_add,
  input  logic [MP-1:0]                 tcdm_wen,
  input  logic [MP-1:0][TCDM_BW-1:0]    tcdm_be,
  input  logic [MP-1:0][TCDM_DW-1:0]    tcdm_data,
  output logic [MP-1:0][TCDM_DW-1:0]    tcdm_r_data,
  output logic [MP-1:0]                 tcdm_r_valid,
  input  logic [N_BANKS-1:0]            stall_i
);
  localparam int BB = $clog2(N_BANKS);
  localparam int RW = $clog2(BANK_WORDS);
  localparam int PW = (MP > 1) ? $clog2(MP) : 1;

  tcdm_req_t [MP-1:0]          port_req;
  logic [MP-1:0][BB-1:0]       port_bank;
  logic [MP-1:0][RW-1:0]       port_row;
  logic [MP-1:0]               unused_add;

  logic [N_BANKS-1:0]          bank_gnt;
  logic [N_BANKS-1:0][PW-1:0]  win, rr_d, rr_q;
  logic [N_BANKS-1:0]          bank_vld;
  logic [N_BANKS-1:0][PW-1:0]  bank_own;
  logic [N_BANKS-1:0][TCDM_DW-1:0] bank_rdata;

  for (genvar p = 0; p < MP; p++) begin : g_port
    assign port_req[p]   = '{add: tcdm_add[p], wen: tcdm_wen[p], be: tcdm_be[p], data: tcdm_data[p]};
    assign port_bank[p]  = port_req[p].add[2 +: BB];
    // High bits beyond the array wrap silently.
    assign port_row[p]   = port_req[p].add[2+BB +: RW];
    assign unused_add[p] = ^{port_req[p].add[1:0], port_req[p].add[31:2+BB+RW]};
  end

  always_comb begin
    bank_gnt = '0;
    win      = '0;
    rr_d     = rr_q;
    tcdm_gnt = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (!stall_i[b]) begin
        for (int k = 0; k < MP; k++) begin
          if (!bank_gnt[b] && tcdm_req[(int'(rr_q[b]) + k) % MP] &&
              port_bank[(int'(rr_q[b]) + k) % MP] == BB'(b)) begin
            bank_gnt[b] = 1'b1;
            win[b]      = PW'((int'(rr_q[b]) + k) % MP);
          end
        end
      end
      if (bank_gnt[b]) begin
        rr_d[b] = PW'((int'(win[b]) + 1) % MP);
        tcdm_gnt[win[b]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    fir_tcdm_bank #(.BANK_WORDS(BANK_WORDS), .OW(PW), .RW(RW)) u_bank (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .gnt_i    (bank_gnt[b]),
      .owner_i  (win[b]),
      .row_i    (port_row[win[b]]),
      .wen_i    (port_req[win[b]].wen),
      .be_i     (port_req[win[b]].be),
      .wdata_i  (port_req[win[b]].data),
      .rvalid_o (bank_vld[b]),
      .owner_o  (bank_own[b]),
      .rdata_o  (bank_rdata[b])
    );
  end

  // A port wins at most one bank per cycle, so at most one tag matches.
  always_comb begin
    tcdm_r_valid = '0;
    tcdm_r_data  = '0;
    for (int p = 0; p < MP; p++)
      for (int b = 0; b < N_BANKS; b++)
        if (bank_vld[b] && bank_own[b] == PW'(p)) begin
          tcdm_r_valid[p] = 1'b1;
          tcdm_r_data[p]  = bank_rdata[b];
        end
  end
endmodule

// File: tb/tb_fir_tcdm_responder.sv
// Bench for fir_tcdm_responder: directed per-cycle vector table, a reset
// corner-case sequence, and randomized traffic against a word-array model.
module tb_fir_tcdm_responder;
  import fir_package::*;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic [3:0]        req, wen, gnt, rv;
  logic [3:0][31:0]  add, data, rd;
  logic [3:0][3:0]   be;
  logic [7:0]        stall;
  int                tests = 0;
  int                fails = 0;

  always #5 clk = ~clk;

  fir_tcdm_responder #(.MP(4), .N_BANKS(8), .BANK_WORDS(256)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .tcdm_req     (req),
    .tcdm_gnt     (gnt),
    .tcdm_add     (add),
    .tcdm_wen     (wen),
    .tcdm_be      (be),
    .tcdm_data    (data),
    .tcdm_r_data  (rd),
    .tcdm_r_valid (rv),
    .stall_i      (stall)
  );

  typedef struct {
    logic [3:0]           req;
    tcdm_req_t [3:0]      q;
    logic [7:0]           stall;
    logic [3:0]           gnt;
    logic [3:0]           rv;
    logic [3:0][31:0]     rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.req = '0; v.q = '0; v.stall = '0; v.gnt = '0; v.rv = '0; v.rd = '0;
    return v;
  endfunction

  function automatic vec_t one(int p, logic [31:0] a, logic w, logic [3:0] b,
                               logic [31:0] d, logic [7:0] st, logic g, logic [31:0] r);
    vec_t v = blank();
    v.req[p] = 1'b1;
    v.q[p]   = '{add: a, wen: w, be: b, data: d};
    v.stall  = st;
    v.gnt[p] = g;
    v.rv[p]  = g;
    v.rd[p]  = r;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    req   = v.req;
    stall = v.stall;
    for (int p = 0; p < 4; p++) begin
      add[p]  = v.q[p].add;
      wen[p]  = v.q[p].wen;
      be[p]   = v.q[p].be;
      data[p] = v.q[p].data;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    apply(v);
    #1 chk({tag, " gnt"}, gnt, v.gnt);
    @(posedge clk);
    #1;
    chk({tag, " r_valid"}, rv, v.rv);
    chk({tag, " r_data"}, rd, v.rd);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    req    = '0;
    stall  = '0;
    #1;
    chk("reset r_valid", rv, 4'h0);
    chk("reset r_data", rd, 128'h0);
    chk("reset gnt", gnt, 4'h0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
  endtask

  // Reference model: flat word memory indexed by word address mod total words.
  logic [31:0] mdl_mem [2048];
  int          mdl_rr  [8];

  initial begin
    vec_t v;
    logic [3:0][31:0] dpat;
    logic [3:0]       eg;
    logic [3:0][31:0] erd;

    rst_ni = 1'b0; req = '0; add = '0; wen = '0; be = '0; data = '0; stall = '0;
    for (int p = 0; p < 4; p++) dpat[p] = 32'hC0DE0000 + 32'(p) * 32'h1111;

    // All four ports contend for bank 0, round-robin from port 0.
    v = blank();
    v.req = 4'hF;
    for (int p = 0; p < 4; p++) v.q[p] = '{add: 32'(p * 32), wen: 1'b1, be: 4'hF, data: 32'h0};
    for (int i = 0; i < 5; i++) begin
      v.gnt = 4'(1 << (i % 4));
      v.rv  = v.gnt;
      vecs.push_back(v);
    end
    // Parallel writes to banks 0..3, then crossed parallel reads.
    v = blank();
    v.req = 4'hF; v.gnt = 4'hF; v.rv = 4'hF;
    for (int p = 0; p < 4; p++) v.q[p] = '{add: 32'(4 * p), wen: 1'b0, be: 4'hF, data: dpat[p]};
    vecs.push_back(v);
    for (int p = 0; p < 4; p++) begin
      v.q[p] = '{add: 32'(12 - 4 * p), wen: 1'b1, be: 4'hF, data: 32'h0};
      v.rd[p] = dpat[3 - p];
    end
    vecs.push_back(v);
    // Single write/read, then partial byte enables.
    vecs.push_back(one(0, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF, 8'h00, 1'b1, 32'h0));
    vecs.push_back(one(0, 32'h40, 1'b1, 4'hF, 32'h0,        8'h00, 1'b1, 32'hDEADBEEF));
    vecs.push_back(one(0, 32'h80, 1'b0, 4'hF, 32'hFFFFFFFF, 8'h00, 1'b1, 32'h0));
    vecs.push_back(one(0, 32'h80, 1'b0, 4'h5, 32'h00000000, 8'h00, 1'b1, 32'h0));
    vecs.push_back(one(0, 32'h80, 1'b1, 4'hF, 32'h0,        8'h00, 1'b1, 32'hFF00FF00));
    // Forced stall on bank 2 for three cycles.
    for (int i = 0; i < 3; i++)
      vecs.push_back(one(1, 32'h08, 1'b1, 4'hF, 32'h0, 8'h04, 1'b0, 32'h0));
    vecs.push_back(one(1, 32'h08, 1'b1, 4'hF, 32'h0, 8'h00, 1'b1, dpat[2]));
    // Address past the array aliases back onto 0x08.
    vecs.push_back(one(1, 32'h2008, 1'b0, 4'hF, 32'hA5A55A5A, 8'h00, 1'b1, 32'h0));
    vecs.push_back(one(1, 32'h08,   1'b1, 4'hF, 32'h0,        8'h00, 1'b1, 32'hA5A55A5A));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while a response is in flight.
    @(negedge clk);
    apply(one(0, 32'h100, 1'b0, 4'hF, 32'h12345678, 8'h00, 1'b1, 32'h0));
    #1 chk("midrst gnt", gnt, 4'h1);
    @(posedge clk);
    #1 chk("midrst r_valid before", rv, 4'h1);
    rst_ni = 1'b0;
    #1;
    chk("midrst r_valid async", rv, 4'h0);
    chk("midrst r_data async", rd, 128'h0);
    req = '0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    run_vec(one(0, 32'h100, 1'b1, 4'hF, 32'h0, 8'h00, 1'b1, 32'h0), "midrst readback");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 2048; i++) mdl_mem[i] = '0;
    for (int b = 0; b < 8; b++) mdl_rr[b] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
        req[p]  = $urandom_range(0, 3) != 0;
        wen[p]  = $urandom_range(0, 1) != 0;
        be[p]   = 4'($urandom_range(0, 15));
        data[p] = $urandom;
        add[p]  = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3))
                | (32'($urandom_range(0, 3)) << 13);
      end
      for (int b = 0; b < 8; b++) stall[b] = $urandom_range(0, 5) == 0;

      eg = '0;
      for (int b = 0; b < 8; b++) begin
        int found;
        found = 0;
        if (!stall[b])
          for (int k = 0; k < 4; k++) begin
            int p;
            p = (mdl_rr[b] + k) % 4;
            if (found == 0 && req[p] && int'((add[p] >> 2) % 8) == b) begin
              eg[p] = 1'b1;
              mdl_rr[b] = (p + 1) % 4;
              found = 1;
            end
          end
      end
      #1 chk($sformatf("rand%0d gnt", c), gnt, eg);

      erd = '0;
      for (int p = 0; p < 4; p++)
        if (eg[p]) begin
          int w;
          w = int'((add[p] >> 2) % 2048);
          if (wen[p]) erd[p] = mdl_mem[w];
          else
            for (int j = 0; j < 4; j++)
              if (be[p][j]) mdl_mem[w][8*j +: 8] = data[p][8*j +: 8];
        end
      @(posedge clk);
      #1;
      chk($sformatf("rand%0d r_valid", c), rv, eg);
      chk($sformatf("rand%0d r_data", c), rd, erd);
    end

    req = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
